// File: rtl/bin_bcd_conv.sv
// rtl/bin_bcd_conv.sv - sequential shift-add-3 binary-to-BCD converter, one bit per clock
// Start/done handshake; saturates to all nines with ovf when the value needs more than DIGITS digits.
module bin_bcd_conv #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] shift_q, shift_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_acc_q, ovf_acc_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   nines;
  logic [BW-1:0]   next_digits;
  logic            ovf_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      digits_q  <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    adj   = digits_q;
    nines = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      nines[4*i +: 4] = 4'd9;
    end
    // The bit leaving the top digit means the value needs more digits than we have.
    next_digits = {adj[BW-2:0], shift_q[IN_W-1]};
    ovf_step    = ovf_acc_q | adj[BW-1];

    state_d   = state_q;
    shift_d   = shift_q;
    digits_d  = digits_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          digits_d  = '0;
          cnt_d     = CW'(IN_W - 1);
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        digits_d  = next_digits;
        ovf_acc_d = ovf_step;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = ovf_step ? nines : next_digits;
          ovf_d   = ovf_step;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
endmodule
